// File: rtl/ahb_apb_bridge_pn.sv
`timescale 1ns/1ps
// AHB-to-APB bridge: configurable windows, PREADY wait states, PSLVERR/decode-miss
// error responses and an ACCESS-phase watchdog.
module ahb_apb_bridge_pn #(
  parameter int                     ADDR_W      = 40,
  parameter int                     DATA_W      = 32,
  parameter int                     NSLV        = 9,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE    = '0,
  parameter int                     SLV_SZ_LOG2 = 12,
  parameter int                     TIMEOUT     = 256
) (
  input  logic                   hclk,
  input  logic                   hrst,
  input  logic                   harb_apb_hsel,
  input  logic [1:0]             harb_xx_htrans,
  input  logic                   harb_xx_hready,
  input  logic [ADDR_W-1:0]      harb_xx_haddr,
  input  logic                   harb_xx_hwrite,
  input  logic [DATA_W-1:0]      harb_xx_hwdata,
  output logic [DATA_W-1:0]      apb_harb_hrdata,
  output logic                   apb_harb_hready,
  output logic [1:0]             apb_harb_hresp,
  output logic [ADDR_W-1:0]      apb_xx_paddr,
  output logic                   apb_xx_pwrite,
  output logic [DATA_W-1:0]      apb_xx_pwdata,
  output logic                   apb_xx_penable,
  output logic [NSLV-1:0]        apb_xx_psel,
  input  logic [NSLV*DATA_W-1:0] prdata_s,
  input  logic [NSLV-1:0]        pready_s,
  input  logic [NSLV-1:0]        pslverr_s
);

  localparam int   SLOT_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int   CNT_W  = $clog2(TIMEOUT) + 1;
  localparam int   WIN_W  = ADDR_W - SLV_SZ_LOG2;
  localparam bit   TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DERR, S_ERR2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                penable_q;
  logic [NSLV-1:0]     psel_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                acc;
  logic                hit_d;
  logic [SLOT_W-1:0]   slot_d;
  logic                pready_sel;
  logic                pslverr_sel;
  logic [DATA_W-1:0]   prdata_sel;
  logic                acc_ok;
  logic                acc_slverr;
  logic                acc_tout;
  logic                sample;
  logic                unused_htrans0;

  function automatic logic [NSLV-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
    logic [NSLV-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign unused_htrans0 = harb_xx_htrans[0];
  assign acc            = harb_apb_hsel & harb_xx_htrans[1] & harb_xx_hready;

  // Descending scan so the lowest matching slot is the one left standing.
  always_comb begin
    hit_d  = 1'b0;
    slot_d = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (harb_xx_haddr[ADDR_W-1:SLV_SZ_LOG2] == SLV_BASE[i*ADDR_W+SLV_SZ_LOG2 +: WIN_W]) begin
        hit_d  = 1'b1;
        slot_d = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        pready_sel  = pready_s[i];
        pslverr_sel = pslverr_s[i];
        prdata_sel  = prdata_s[i*DATA_W +: DATA_W];
      end
    end
  end

  assign acc_ok     = (state_q == S_ACCESS) & pready_sel & ~pslverr_sel;
  assign acc_slverr = (state_q == S_ACCESS) & pready_sel & pslverr_sel;
  assign acc_tout   = (state_q == S_ACCESS) & TO_EN & ~pready_sel & (cnt_q == CNT_LAST);
  assign sample     = (state_q == S_IDLE) | (state_q == S_ERR2) | acc_ok;

  always_comb begin
    apb_harb_hready = 1'b1;
    apb_harb_hresp  = 2'b00;
    apb_harb_hrdata = '0;
    case (state_q)
      S_WDATA, S_SETUP: apb_harb_hready = 1'b0;
      S_DERR: begin
        apb_harb_hready = 1'b0;
        apb_harb_hresp  = 2'b01;
      end
      S_ERR2: apb_harb_hresp = 2'b01;
      S_ACCESS: begin
        apb_harb_hready = pready_sel & ~pslverr_sel;
        if (acc_slverr | acc_tout) apb_harb_hresp = 2'b01;
        if (!pwrite_q) apb_harb_hrdata = prdata_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      slot_q    <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      cnt_q     <= '0;
    end else if (sample) begin
      penable_q <= 1'b0;
      if (acc && !hit_d) begin
        state_q <= S_DERR;
        psel_q  <= '0;
      end else if (acc && harb_xx_hwrite) begin
        state_q <= S_WDATA;
        addr_q  <= harb_xx_haddr;
        slot_q  <= slot_d;
        psel_q  <= '0;
      end else if (acc) begin
        // Reads skip WDATA, so the APB address is loaded straight from the bus.
        state_q  <= S_SETUP;
        addr_q   <= harb_xx_haddr;
        slot_q   <= slot_d;
        paddr_q  <= harb_xx_haddr;
        pwrite_q <= 1'b0;
        psel_q   <= slot_onehot(slot_d);
        cnt_q    <= '0;
      end else begin
        state_q <= S_IDLE;
        psel_q  <= '0;
      end
    end else begin
      case (state_q)
        S_WDATA: begin
          state_q  <= S_SETUP;
          pwdata_q <= harb_xx_hwdata;
          paddr_q  <= addr_q;
          pwrite_q <= 1'b1;
          psel_q   <= slot_onehot(slot_q);
          cnt_q    <= '0;
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          if (acc_slverr || acc_tout) begin
            state_q   <= S_ERR2;
            psel_q    <= '0;
            penable_q <= 1'b0;
          end else if (TO_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DERR:  state_q <= S_ERR2;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign apb_xx_paddr   = paddr_q;
  assign apb_xx_pwrite  = pwrite_q;
  assign apb_xx_pwdata  = pwdata_q;
  assign apb_xx_penable = penable_q;
  assign apb_xx_psel    = psel_q;

endmodule

// File: tb/tb_ahb_apb_bridge_pn.sv
`timescale 1ns/1ps
// Bench for ahb_apb_bridge_pn: directed scenarios plus randomized transfers
// checked against a transaction-level model of the bridge's cycle behaviour.
module tb_ahb_apb_bridge_pn;

  localparam int TO_A = 4;
  localparam logic [9*40-1:0] BASES = {
    40'h10019000, 40'h1001C000, 40'h1001B000, 40'h1001A000, 40'h10019000,
    40'h10018000, 40'h10017000, 40'h10016000, 40'h10015000};
  localparam logic [39:0] BASE_TBL [9] = '{
    40'h10015000, 40'h10016000, 40'h10017000, 40'h10018000, 40'h10019000,
    40'h1001A000, 40'h1001B000, 40'h1001C000, 40'h10019000};

  logic         clk = 1'b0;
  logic         hrst;
  logic         hsel;
  logic [1:0]   htrans;
  logic [39:0]  haddr;
  logic         hwrite;
  logic [31:0]  hwdata;
  logic [287:0] prdata_s;
  logic [8:0]   pready_s, pslverr_s;

  logic [31:0]  a_hrdata, b_hrdata, a_pwdata, b_pwdata;
  logic         a_hready, b_hready, a_pwrite, b_pwrite, a_penable, b_penable;
  logic [1:0]   a_hresp, b_hresp;
  logic [39:0]  a_paddr, b_paddr;
  logic [8:0]   a_psel, b_psel;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] exp_pwdata;

  always #5 clk = ~clk;

  ahb_apb_bridge_pn #(.ADDR_W(40), .DATA_W(32), .NSLV(9), .SLV_BASE(BASES),
                      .SLV_SZ_LOG2(12), .TIMEOUT(TO_A)) dut_a (
    .hclk(clk), .hrst(hrst), .harb_apb_hsel(hsel), .harb_xx_htrans(htrans),
    .harb_xx_hready(a_hready), .harb_xx_haddr(haddr), .harb_xx_hwrite(hwrite),
    .harb_xx_hwdata(hwdata), .apb_harb_hrdata(a_hrdata), .apb_harb_hready(a_hready),
    .apb_harb_hresp(a_hresp), .apb_xx_paddr(a_paddr), .apb_xx_pwrite(a_pwrite),
    .apb_xx_pwdata(a_pwdata), .apb_xx_penable(a_penable), .apb_xx_psel(a_psel),
    .prdata_s(prdata_s), .pready_s(pready_s), .pslverr_s(pslverr_s));

  ahb_apb_bridge_pn #(.ADDR_W(40), .DATA_W(32), .NSLV(9), .SLV_BASE(BASES),
                      .SLV_SZ_LOG2(12), .TIMEOUT(0)) dut_b (
    .hclk(clk), .hrst(hrst), .harb_apb_hsel(hsel), .harb_xx_htrans(htrans),
    .harb_xx_hready(b_hready), .harb_xx_haddr(haddr), .harb_xx_hwrite(hwrite),
    .harb_xx_hwdata(hwdata), .apb_harb_hrdata(b_hrdata), .apb_harb_hready(b_hready),
    .apb_harb_hresp(b_hresp), .apb_xx_paddr(b_paddr), .apb_xx_pwrite(b_pwrite),
    .apb_xx_pwdata(b_pwdata), .apb_xx_penable(b_penable), .apb_xx_psel(b_psel),
    .prdata_s(prdata_s), .pready_s(pready_s), .pslverr_s(pslverr_s));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [39:0] a);
    for (int i = 0; i < 9; i++)
      if ((a >> 12) == (BASE_TBL[i] >> 12)) return i;
    return -1;
  endfunction

  function automatic logic [287:0] rand_bus();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input logic [39:0] a, input logic w);
    hsel   = 1'b1;
    htrans = {1'b1, 1'($urandom_range(0, 1))};
    haddr  = a;
    hwrite = w;
    hwdata = $urandom;
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = {8'h00, $urandom};
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, ".hready"}, a_hready, 1);
    chk({tag, ".hresp"}, a_hresp, 0);
    chk({tag, ".psel"}, a_psel, 0);
    chk({tag, ".penable"}, a_penable, 0);
    chk({tag, ".hrdata"}, a_hrdata, 0);
  endtask

  task automatic chk_err2();
    @(negedge clk);
    chk("err2.hready", a_hready, 1);
    chk("err2.hresp", a_hresp, 2'b01);
    chk("err2.psel", a_psel, 0);
    chk("err2.penable", a_penable, 0);
  endtask

  // Called one cycle after the address phase was accepted; returns at the
  // sampling point of the cycle that can accept the next address phase.
  task automatic body(input logic [39:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input logic err);
    int s, n_acc;
    logic to, rdy;
    logic [8:0] oh;
    s = decode(addr);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    pready_s = 9'($urandom); pslverr_s = 9'($urandom); prdata_s = rand_bus();
    if (s < 0) begin
      @(negedge clk);
      chk("derr.hready", a_hready, 0);
      chk("derr.hresp", a_hresp, 2'b01);
      chk("derr.psel", a_psel, 0);
      chk("derr.penable", a_penable, 0);
      step();
      chk_err2();
      return;
    end
    oh = 9'(1) << s;
    if (wr) begin
      @(negedge clk);
      chk("wdata.hready", a_hready, 0);
      chk("wdata.hresp", a_hresp, 0);
      chk("wdata.psel", a_psel, 0);
      step();
      hwdata = $urandom;
      exp_pwdata = wd;
    end
    @(negedge clk);
    chk("setup.hready", a_hready, 0);
    chk("setup.psel", a_psel, oh);
    chk("setup.penable", a_penable, 0);
    chk("setup.paddr", a_paddr, addr);
    chk("setup.pwrite", a_pwrite, wr);
    chk("setup.pwdata", a_pwdata, exp_pwdata);
    chk("setup.hrdata", a_hrdata, 0);
    step();
    to = (TO_A != 0) && (waits >= TO_A);
    n_acc = to ? TO_A : waits + 1;
    for (int k = 0; k < n_acc; k++) begin
      rdy = (k == waits);
      pready_s  = (9'($urandom) & ~oh) | (rdy ? oh : 9'd0);
      pslverr_s = (9'($urandom) & ~oh) |
                  (((rdy && err) || (!rdy && $urandom_range(0, 1) == 1)) ? oh : 9'd0);
      prdata_s = rand_bus();
      prdata_s[s*32 +: 32] = rd;
      @(negedge clk);
      chk("acc.penable", a_penable, 1);
      chk("acc.psel", a_psel, oh);
      chk("acc.paddr", a_paddr, addr);
      chk("acc.hready", a_hready, rdy && !err);
      chk("acc.hresp", a_hresp, ((rdy && err) || (to && k == n_acc - 1)) ? 2'b01 : 2'b00);
      chk("acc.hrdata", a_hrdata, wr ? 32'd0 : rd);
      if (k < n_acc - 1) step();
    end
    if (to || err) begin
      step();
      pready_s = 9'($urandom) & ~oh;
      pslverr_s = 9'($urandom);
      chk_err2();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [39:0] a;
    logic [8:0] oh2;
    hrst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = '0;
    prdata_s = '0; pready_s = '0; pslverr_s = '0; exp_pwdata = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst.hready", a_hready, 1);
    chk("rst.hresp", a_hresp, 0);
    chk("rst.hrdata", a_hrdata, 0);
    chk("rst.psel", a_psel, 0);
    chk("rst.penable", a_penable, 0);
    chk("rst.paddr", a_paddr, 0);
    chk("rst.pwrite", a_pwrite, 0);
    chk("rst.pwdata", a_pwdata, 0);
    hrst = 1'b0;
    step();

    // Zero-wait read of slot 0
    drive_addr(40'h10015004, 1'b0); step();
    body(40'h10015004, 1'b0, 32'h0, 32'hA5A50001, 0, 1'b0);
    drive_idle(); step(); chk_idle("rd0.after");

    // Write to slot 3 with three PREADY-low cycles
    drive_addr(40'h10018010, 1'b1); step();
    body(40'h10018010, 1'b1, 32'h12345678, 32'h0, 3, 1'b0);
    drive_idle(); step(); chk_idle("wr3.after");

    // Unmapped read
    drive_addr(40'h0020000000, 1'b0); step();
    body(40'h0020000000, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    drive_idle(); step(); chk_idle("miss.after");

    // PSLVERR on slot 1
    drive_addr(40'h10016008, 1'b0); step();
    body(40'h10016008, 1'b0, 32'h0, 32'h5A5A0002, 0, 1'b1);
    drive_idle(); step(); chk_idle("slverr.after");

    // Back-to-back read, read, write; overlapping window resolves to slot 4
    drive_addr(40'h10017100, 1'b0); step();
    body(40'h10017100, 1'b0, 32'h0, 32'h11112222, 1, 1'b0);
    drive_addr(40'h10019200, 1'b0); step();
    body(40'h10019200, 1'b0, 32'h0, 32'h33334444, 0, 1'b0);
    drive_addr(40'h1001B030, 1'b1); step();
    body(40'h1001B030, 1'b1, 32'hCAFEF00D, 32'h0, 2, 1'b0);
    drive_idle(); step(); chk_idle("b2b.after");

    // Accept directly out of ERR2, then a non-accepted BUSY cycle
    drive_addr(40'h0030001000, 1'b1); step();
    body(40'h0030001000, 1'b1, 32'h0, 32'h0, 0, 1'b0);
    drive_addr(40'h1001C004, 1'b0); step();
    body(40'h1001C004, 1'b0, 32'h0, 32'h77778888, 0, 1'b0);
    hsel = 1'b1; htrans = 2'b01; haddr = 40'h10015000; hwrite = 1'b0;
    step(); chk_idle("busy");
    hsel = 1'b0; htrans = 2'b10;
    step(); chk_idle("nosel");

    // Watchdog: A (TIMEOUT=4) errors, B (TIMEOUT=0) keeps waiting
    hrst = 1'b1; step(); hrst = 1'b0; exp_pwdata = '0;
    drive_addr(40'h10017040, 1'b0); step();
    body(40'h10017040, 1'b0, 32'h0, 32'h9ABCDEF0, 100, 1'b0);
    drive_idle();
    oh2 = 9'b000000100;
    for (int c = 0; c < 1000; c++) begin
      pready_s = 9'($urandom) & ~oh2;
      pslverr_s = 9'($urandom) & ~oh2;
      step();
    end
    @(negedge clk);
    chk("to0.hready", b_hready, 0);
    chk("to0.hresp", b_hresp, 0);
    chk("to0.penable", b_penable, 1);
    chk("to0.psel", b_psel, oh2);
    chk("to0.a_psel", a_psel, 0);
    pready_s = oh2; pslverr_s = 9'd0; prdata_s = rand_bus(); prdata_s[2*32 +: 32] = 32'h9ABCDEF0;
    #1;
    chk("to0.done_hready", b_hready, 1);
    chk("to0.done_hrdata", b_hrdata, 32'h9ABCDEF0);
    step();
    @(negedge clk);
    chk("to0.idle_psel", b_psel, 0);
    chk("to0.idle_hready", b_hready, 1);

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      int i, waits;
      logic w, e;
      if ($urandom_range(0, 4) == 0) begin
        hsel = 1'($urandom_range(0, 1)); htrans = hsel ? 2'b01 : 2'b10;
        step(); chk_idle("rnd.noacc");
      end
      if ($urandom_range(0, 3) == 0) a = {8'h00, $urandom};
      else begin
        i = $urandom_range(0, 8);
        a = BASE_TBL[i] + 40'($urandom_range(0, 1023) * 4);
      end
      w = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) == 0);
      waits = $urandom_range(0, 5);
      drive_addr(a, w); step();
      body(a, w, $urandom, $urandom, waits, e);
    end
    drive_idle(); step(); chk_idle("rnd.after");

    // Reset in the middle of a write's ACCESS phase
    drive_addr(40'h10015020, 1'b1); step();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hDEADBEEF;
    step();
    step();
    pready_s = 9'($urandom) & ~9'h001;
    @(negedge clk);
    chk("midrst.pre_penable", a_penable, 1);
    chk("midrst.pre_pwdata", a_pwdata, 32'hDEADBEEF);
    hrst = 1'b1;
    step();
    @(negedge clk);
    chk("midrst.psel", a_psel, 0);
    chk("midrst.penable", a_penable, 0);
    chk("midrst.hready", a_hready, 1);
    chk("midrst.hresp", a_hresp, 0);
    chk("midrst.paddr", a_paddr, 0);
    chk("midrst.pwrite", a_pwrite, 0);
    chk("midrst.pwdata", a_pwdata, 0);
    hrst = 1'b0; exp_pwdata = '0;
    drive_idle(); step(); chk_idle("midrst.after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
